// File: rtl/reg_rw_arbiter.sv
// Shares one single-port, two-cycle-latency register BRAM between a data-plane requester
// (read/write/atomic add) and a control-plane requester (read/write). Optional macro
// REG_RW_SATURATE_EN makes the atomic add clamp on unsigned carry-out instead of wrapping.
module reg_rw_arbiter #(
   parameter int unsigned L2_DEPTH = 8,
   parameter int unsigned WIDTH    = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                dp_req_valid,
   output logic                dp_req_ready,
   input  logic [1:0]          dp_req_op,
   input  logic [L2_DEPTH-1:0] dp_req_index,
   input  logic [WIDTH-1:0]    dp_req_data,
   output logic                dp_resp_valid,
   output logic [WIDTH-1:0]    dp_resp_data,
   input  logic                cp_req_valid,
   output logic                cp_req_ready,
   input  logic                cp_req_we,
   input  logic [L2_DEPTH-1:0] cp_req_index,
   input  logic [WIDTH-1:0]    cp_req_data,
   output logic                cp_resp_valid,
   output logic [WIDTH-1:0]    cp_resp_data,
   output logic                bram_en,
   output logic                bram_we,
   output logic [L2_DEPTH-1:0] bram_addr,
   output logic [WIDTH-1:0]    bram_din,
   output logic                bram_regce,
   output logic                bram_rst,
   input  logic [WIDTH-1:0]    bram_dout
);

   typedef enum logic [1:0] {StIdle, StRmwRd1, StRmwRd2, StRmwWr} state_e;

   state_e              state_q, state_d;
   logic                rr_cp_q, rr_cp_d;
   logic [L2_DEPTH-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]    opnd_q, opnd_d;
   logic [WIDTH-1:0]    sum_q, sum_d;
   logic                tag1_vld_q, tag1_vld_d;
   logic                tag1_cp_q, tag1_cp_d;
   logic                tag2_vld_q, tag2_cp_q;
   logic                en_q;

   logic                grant_dp, grant_cp;
   logic                dp_rdy, cp_rdy;
   logic                en, we;
   logic [L2_DEPTH-1:0] addr;
   logic [WIDTH-1:0]    din;
   logic [WIDTH-1:0]    add_res;

   // Round-robin only matters when both are valid; rr_cp_q gives cp the priority.
   assign grant_dp = dp_req_valid & (~cp_req_valid | ~rr_cp_q);
   assign grant_cp = cp_req_valid & ~grant_dp;

`ifdef REG_RW_SATURATE_EN
   logic [WIDTH:0] add_full;
   assign add_full = {1'b0, bram_dout} + {1'b0, opnd_q};
   assign add_res  = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
`else
   assign add_res  = bram_dout + opnd_q;
`endif

   always_comb begin
      state_d    = state_q;
      rr_cp_d    = rr_cp_q;
      idx_d      = idx_q;
      opnd_d     = opnd_q;
      sum_d      = sum_q;
      tag1_vld_d = 1'b0;
      tag1_cp_d  = 1'b0;
      dp_rdy     = 1'b0;
      cp_rdy     = 1'b0;
      en         = 1'b0;
      we         = 1'b0;
      addr       = '0;
      din        = '0;
      unique case (state_q)
         StIdle: begin
            dp_rdy = grant_dp;
            cp_rdy = grant_cp;
            if (grant_dp) begin
               en         = 1'b1;
               we         = (dp_req_op == 2'b01);
               addr       = dp_req_index;
               din        = dp_req_data;
               tag1_vld_d = 1'b1;
               rr_cp_d    = 1'b1;
               if (dp_req_op == 2'b10) begin
                  state_d = StRmwRd1;
                  idx_d   = dp_req_index;
                  opnd_d  = dp_req_data;
               end
            end else if (grant_cp) begin
               en         = 1'b1;
               we         = cp_req_we;
               addr       = cp_req_index;
               din        = cp_req_data;
               tag1_vld_d = 1'b1;
               tag1_cp_d  = 1'b1;
               rr_cp_d    = 1'b0;
            end
         end
         StRmwRd1: state_d = StRmwRd2;
         StRmwRd2: begin
            sum_d   = add_res;
            state_d = StRmwWr;
         end
         StRmwWr: begin
            // Write-back carries no tag, so it never produces a response.
            en      = 1'b1;
            we      = 1'b1;
            addr    = idx_q;
            din     = sum_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         rr_cp_q    <= 1'b0;
         idx_q      <= '0;
         opnd_q     <= '0;
         sum_q      <= '0;
         tag1_vld_q <= 1'b0;
         tag1_cp_q  <= 1'b0;
         tag2_vld_q <= 1'b0;
         tag2_cp_q  <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_cp_q    <= rr_cp_d;
         idx_q      <= idx_d;
         opnd_q     <= opnd_d;
         sum_q      <= sum_d;
         tag1_vld_q <= tag1_vld_d;
         tag1_cp_q  <= tag1_cp_d;
         tag2_vld_q <= tag1_vld_q;
         tag2_cp_q  <= tag1_cp_q;
         en_q       <= en;
      end
   end

   // Outputs are forced quiet while reset is held, including mid-cycle assertion.
   assign dp_req_ready  = resetn & dp_rdy;
   assign cp_req_ready  = resetn & cp_rdy;
   assign bram_en       = resetn & en;
   assign bram_we       = resetn & we;
   assign bram_addr     = resetn ? addr : '0;
   assign bram_din      = resetn ? din : '0;
   assign bram_regce    = resetn & en_q;
   assign bram_rst      = ~resetn;
   assign dp_resp_valid = resetn & tag2_vld_q & ~tag2_cp_q;
   assign cp_resp_valid = resetn & tag2_vld_q & tag2_cp_q;
   assign dp_resp_data  = dp_resp_valid ? bram_dout : '0;
   assign cp_resp_data  = cp_resp_valid ? bram_dout : '0;

endmodule
